// File: rtl/bsearch_ctrl.sv
// Binary-search controller over a sorted, synchronous-read RAM (ascending, no duplicates).
// Probes mid=(lo+hi)/2, waits RD_LAT cycles for data, then narrows the range or finishes.
module bsearch_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] valueIn,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] addrOut,
  output logic              found,
  output logic              notfound,
  output logic              hide,
  output logic              busy
);

  typedef enum logic [2:0] {StIdle, StProbe, StWait, StCmp, StDone} state_e;

  localparam logic [1:0] CntLast = 2'(RD_LAT - 1);

  state_e              state_q;
  logic [DATA_W-1:0]   key_q;
  logic [ADDR_W-1:0]   lo_q;
  logic [ADDR_W-1:0]   hi_q;
  logic [1:0]          cnt_q;
  logic [ADDR_W:0]     span_sum;
  logic [ADDR_W-1:0]   mid;

  // One extra bit so lo+hi never overflows before halving.
  always_comb begin
    span_sum = {1'b0, lo_q} + {1'b0, hi_q};
    mid      = span_sum[ADDR_W:1];
  end

  // ram_addr doubles as the current mid for the compare stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      key_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      cnt_q    <= '0;
      ram_addr <= '0;
      addrOut  <= '0;
      found    <= 1'b0;
      notfound <= 1'b0;
      hide     <= 1'b1;
      busy     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          found    <= 1'b0;
          notfound <= 1'b0;
          hide     <= 1'b1;
          if (start) begin
            key_q   <= valueIn;
            lo_q    <= '0;
            hi_q    <= '1;
            busy    <= 1'b1;
            state_q <= StProbe;
          end
        end
        StProbe: begin
          ram_addr <= mid;
          cnt_q    <= '0;
          state_q  <= StWait;
        end
        StWait: begin
          if (cnt_q == CntLast) begin
            state_q <= StCmp;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        StCmp: begin
          if (ram_q == key_q) begin
            addrOut <= ram_addr;
            found   <= 1'b1;
            hide    <= 1'b0;
            busy    <= 1'b0;
            state_q <= StDone;
          end else if (ram_q < key_q) begin
            // Range exhausted from below: checked before update so lo never passes the top.
            if (ram_addr == hi_q) begin
              notfound <= 1'b1;
              busy     <= 1'b0;
              state_q  <= StDone;
            end else begin
              lo_q    <= ram_addr + ADDR_W'(1);
              state_q <= StProbe;
            end
          end else begin
            if (ram_addr == lo_q) begin
              notfound <= 1'b1;
              busy     <= 1'b0;
              state_q  <= StDone;
            end else begin
              hi_q    <= ram_addr - ADDR_W'(1);
              state_q <= StProbe;
            end
          end
        end
        StDone: begin
          if (!start) begin
            found    <= 1'b0;
            notfound <= 1'b0;
            hide     <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bsearch_ctrl.sv
// Bench for bsearch_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share stimulus; results are
// checked against a linear-scan reference over the preloaded table.
module tb_bsearch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [7:0]      valueIn = 8'h00;
  logic [1:0][4:0] ra;
  logic [1:0][4:0] ao;
  logic [1:0]      fnd, nf, hd, bz;
  logic [7:0]      q1, q3a, q3b, q3c;
  logic [7:0]      mem [32];

  int checks = 0;
  int errors = 0;

  bsearch_ctrl #(.DATA_W(8), .ADDR_W(5), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .valueIn(valueIn), .ram_addr(ra[0]), .ram_q(q1),
    .addrOut(ao[0]), .found(fnd[0]), .notfound(nf[0]), .hide(hd[0]), .busy(bz[0])
  );

  bsearch_ctrl #(.DATA_W(8), .ADDR_W(5), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .valueIn(valueIn), .ram_addr(ra[1]), .ram_q(q3c),
    .addrOut(ao[1]), .found(fnd[1]), .notfound(nf[1]), .hide(hd[1]), .busy(bz[1])
  );

  // Synchronous-read RAMs with 1 and 3 cycles of latency.
  always @(posedge clk) q1 <= mem[ra[0]];
  always @(posedge clk) begin
    q3a <= mem[ra[1]];
    q3b <= q3a;
    q3c <= q3b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_index(input logic [7:0] v);
    for (int i = 0; i < 32; i++) if (mem[i] == v) return i;
    return -1;
  endfunction

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s/ram_addr%0d", tag, i), 32'(ra[i]), 0);
      check($sformatf("%s/addrOut%0d", tag, i), 32'(ao[i]), 0);
      check($sformatf("%s/found%0d", tag, i), 32'(fnd[i]), 0);
      check($sformatf("%s/notfound%0d", tag, i), 32'(nf[i]), 0);
      check($sformatf("%s/hide%0d", tag, i), 32'(hd[i]), 1);
      check($sformatf("%s/busy%0d", tag, i), 32'(bz[i]), 0);
    end
  endtask

  task automatic search(input logic [7:0] v);
    int         exp_idx;
    int         done_at [2];
    int         gap [2];
    int         lat [2];
    logic [4:0] last_addr [2];
    exp_idx = ref_index(v);
    lat = '{1, 3};
    @(negedge clk);
    valueIn = v;
    start   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      done_at[i]   = 0;
      gap[i]       = 100;
      last_addr[i] = ra[i];
    end
    for (int cyc = 1; cyc <= 40 && (done_at[0] == 0 || done_at[1] == 0); cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        valueIn = ~v;  // key is latched; this must be ignored
        check("busy_after_start0", 32'(bz[0]), 1);
        check("busy_after_start1", 32'(bz[1]), 1);
      end
      for (int i = 0; i < 2; i++) begin
        gap[i]++;
        if (ra[i] !== last_addr[i]) begin
          check($sformatf("addr_hold_L%0d", lat[i]), 32'(gap[i] >= lat[i] + 2), 1);
          gap[i]       = 0;
          last_addr[i] = ra[i];
        end
        if (done_at[i] == 0 && (fnd[i] || nf[i])) done_at[i] = cyc;
      end
    end
    for (int i = 0; i < 2; i++) begin
      string t;
      t = $sformatf("v%02h_L%0d", v, lat[i]);
      check({t, "/completed"}, 32'(done_at[i] != 0), 1);
      check({t, "/latency"}, 32'(done_at[i] <= 1 + 6 * (lat[i] + 2)), 1);
      check({t, "/found"}, 32'(fnd[i]), 32'(exp_idx >= 0));
      check({t, "/notfound"}, 32'(nf[i]), 32'(exp_idx < 0));
      check({t, "/hide"}, 32'(hd[i]), 32'(exp_idx < 0));
      check({t, "/busy_done"}, 32'(bz[i]), 0);
      if (exp_idx >= 0) check({t, "/addrOut"}, 32'(ao[i]), 32'(exp_idx));
    end
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("idle_found%0d", i), 32'(fnd[i]), 0);
      check($sformatf("idle_notfound%0d", i), 32'(nf[i]), 0);
      check($sformatf("idle_hide%0d", i), 32'(hd[i]), 1);
    end
  endtask

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i + 1);
    #2 reset = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    search(8'h21);
    search(8'h19);
    search(8'h05);
    search(8'h00);
    search(8'hFF);
    search(8'h20);
    search(8'h01);
    search(8'h3F);

    // Reset three cycles into a search aborts immediately.
    @(negedge clk);
    valueIn = 8'h21;
    start   = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals("abort");
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    search(8'h05);

    repeat (16) begin
      if ($urandom_range(0, 1) == 1) v = mem[$urandom_range(0, 31)];
      else v = 8'($urandom_range(0, 255));
      search(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
